// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults and constants for the scoreboarded register file
package regfile_sb_pkg;
    localparam int XlenDef = 64;
    localparam int NregsDef = 32;
    localparam int NrdDef = 2;
    localparam logic RegRstVal = 1'b0;
    localparam int RegZero = 0;
    localparam logic ZeroVal = 1'b0;
    localparam logic RstLevel = 1'b1;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register busy bits with set-over-clear priority and per-port lookups
module regfile_sb_scoreboard import regfile_sb_pkg::*; #(
    parameter int NREGS = NregsDef,
    parameter int NRD = NrdDef,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr0_en,
    input  logic [AW-1:0]     clr0_addr,
    input  logic              clr1_en,
    input  logic [AW-1:0]     clr1_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NREGS-1:0]  busy_vec,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy_nxt;
    // a reservation beats a same-cycle clear so the newer producer stays outstanding; x0 never busy
    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            busy_nxt[i] = (i != RegZero) && ((set_en && set_addr == AW'(i)) ||
                (busy_vec[i] && !(clr0_en && clr0_addr == AW'(i)) && !(clr1_en && clr1_addr == AW'(i))));
    end
    // scoreboard state
    always_ff @(posedge clk) begin
        if (rst == RstLevel)
            busy_vec <= '0;
        else
            busy_vec <= busy_nxt;
    end
    for (genvar k = 0; k < NRD; k++) begin : g_lk
        assign rd_busy[k] = busy_vec[rd_addr[k*AW +: AW]];
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: dual-write-back register file with issue scoreboard; REGFILE_SB_BYPASS_EN enables wb forwarding
module regfile_sb import regfile_sb_pkg::*; #(
    parameter int XLEN = XlenDef,
    parameter int NREGS = NregsDef,
    parameter int NRD = NrdDef,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                iss_valid,
    input  logic [NRD-1:0]      iss_src_used,
    input  logic [AW-1:0]       iss_rd,
    input  logic                iss_rd_we,
    output logic                iss_ready,
    input  logic                wb0_valid,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_valid,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [XLEN-1:0]     wb1_data,
    output logic [NREGS-1:0]    busy_vec
);
    logic [XLEN-1:0] regs [NREGS];
    logic [NRD-1:0] src_busy;
    logic [NRD-1:0] byp;
    logic wb0_live, wb1_live, raw, waw, accept;
    assign wb0_live = wb0_valid && wb0_addr != AW'(RegZero);
    assign wb1_live = wb1_valid && wb1_addr != AW'(RegZero);
    assign raw = |(iss_src_used & src_busy & ~byp);
    assign waw = iss_rd_we && busy_vec[iss_rd] && !(wb0_valid && wb0_addr == iss_rd) && !(wb1_valid && wb1_addr == iss_rd);
    assign iss_ready = !raw && !waw;
    assign accept = iss_valid && iss_ready && iss_rd_we && iss_rd != AW'(RegZero);
    regfile_sb_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
        .clk(clk),
        .rst(rst),
        .set_en(accept),
        .set_addr(iss_rd),
        .clr0_en(wb0_valid),
        .clr0_addr(wb0_addr),
        .clr1_en(wb1_valid),
        .clr1_addr(wb1_addr),
        .rd_addr(rd_addr),
        .busy_vec(busy_vec),
        .rd_busy(src_busy)
    );
    // array writes; wb1 is applied last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (rst == RstLevel) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= {XLEN{RegRstVal}};
        end else begin
            if (wb0_live) regs[wb0_addr] <= wb0_data;
            if (wb1_live) regs[wb1_addr] <= wb1_data;
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[k*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
        logic hit0, hit1;
        assign hit0 = wb0_live && wb0_addr == ra;
        assign hit1 = wb1_live && wb1_addr == ra;
        assign byp[k] = hit0 || hit1;
        assign rd_data[k*XLEN +: XLEN] = ra == AW'(RegZero) ? {XLEN{ZeroVal}} :
            hit1 ? wb1_data : hit0 ? wb0_data : regs[ra];
`else
        assign byp[k] = 1'b0;
        assign rd_data[k*XLEN +: XLEN] = ra == AW'(RegZero) ? {XLEN{ZeroVal}} : regs[ra];
`endif
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven scoreboard bench for regfile_sb
module tb_regfile_sb;
    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic iss_valid = 1'b0;
    logic [NRD-1:0] iss_src_used = '0;
    logic [AW-1:0] iss_rd = '0;
    logic iss_rd_we = 1'b0;
    logic iss_ready;
    logic wb0_valid = 1'b0;
    logic [AW-1:0] wb0_addr = '0;
    logic [XLEN-1:0] wb0_data = '0;
    logic wb1_valid = 1'b0;
    logic [AW-1:0] wb1_addr = '0;
    logic [XLEN-1:0] wb1_data = '0;
    logic [NREGS-1:0] busy_vec;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .iss_valid(iss_valid), .iss_src_used(iss_src_used), .iss_rd(iss_rd),
        .iss_rd_we(iss_rd_we), .iss_ready(iss_ready),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .busy_vec(busy_vec)
    );

    typedef struct {
        logic w0v; logic [4:0] w0a; logic [63:0] w0d;
        logic w1v; logic [4:0] w1a; logic [63:0] w1d;
        logic iv; logic [4:0] ird; logic iwe; logic [1:0] su;
        logic [4:0] a0; logic [4:0] a1;
        logic [63:0] e0; logic [63:0] e1; logic [31:0] eb; logic er;
    } vec_t;

    typedef struct {
        int tag; logic [63:0] d0; logic [63:0] d1; logic [31:0] busy; logic rdy;
    } exp_t;

    exp_t q[$];
    vec_t tbl[14];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    task automatic idle();
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
        iss_valid = 0; iss_rd = 0; iss_rd_we = 0; iss_src_used = 0;
        rd_addr = 0;
    endtask

    task automatic rd(logic [4:0] a0, logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic run(int tag, logic [63:0] e0, logic [63:0] e1, logic [31:0] eb, logic er);
        exp_t e;
        q.push_back('{tag, e0, e1, eb, er});
        @(negedge clk);
        e = q.pop_front();
        chk($sformatf("t%0d.rd0", e.tag), rd_data[63:0], e.d0);
        chk($sformatf("t%0d.rd1", e.tag), rd_data[127:64], e.d1);
        chk($sformatf("t%0d.busy", e.tag), 64'(busy_vec), 64'(e.busy));
        chk($sformatf("t%0d.ready", e.tag), 64'(iss_ready), 64'(e.rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{0,0,0,         0,0,0,          0,0,0,2'b00, 1,31, 0,0,                   0,1};
        tbl[1]  = '{1,1,64'h11,    1,2,64'h22,     0,0,0,2'b00, 3,4,  0,0,                   0,1};
        tbl[2]  = '{1,5,64'hAAAA,  1,5,64'h5555,   0,0,0,2'b00, 1,2,  64'h11,64'h22,         0,1};
        tbl[3]  = '{0,0,0,         1,0,64'hFFFF,   1,0,1,2'b00, 5,0,  64'h5555,0,            0,1};
        tbl[4]  = '{0,0,0,         0,0,0,          1,7,1,2'b00, 0,5,  0,64'h5555,            0,1};
        tbl[5]  = '{0,0,0,         0,0,0,          1,8,1,2'b01, 7,1,  0,64'h11,              32'h80,0};
        tbl[6]  = '{0,0,0,         0,0,0,          1,8,1,2'b10, 7,1,  0,64'h11,              32'h80,1};
        tbl[7]  = '{0,0,0,         0,0,0,          1,8,1,2'b00, 2,3,  64'h22,0,              32'h180,0};
        tbl[8]  = '{0,0,0,         0,0,0,          1,8,0,2'b00, 2,3,  64'h22,0,              32'h180,1};
        tbl[9]  = '{0,0,0,         1,8,64'h88,     1,8,1,2'b00, 1,2,  64'h11,64'h22,         32'h180,1};
        tbl[10] = '{1,7,64'h77,    0,0,0,          0,0,0,2'b00, 8,1,  64'h88,64'h11,         32'h180,1};
        tbl[11] = '{1,8,64'h99,    0,0,0,          0,0,0,2'b00, 7,9,  64'h77,0,              32'h100,1};
        tbl[12] = '{0,0,0,         0,0,0,          0,3,1,2'b00, 8,7,  64'h99,64'h77,         0,1};
        tbl[13] = '{0,0,0,         0,0,0,          0,0,0,2'b11, 3,3,  0,0,                   0,1};

        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(32 - i));
            run(i, 0, 0, 0, 1);
        end

        for (int i = 0; i < 14; i++) begin
            wb0_valid = tbl[i].w0v; wb0_addr = tbl[i].w0a; wb0_data = tbl[i].w0d;
            wb1_valid = tbl[i].w1v; wb1_addr = tbl[i].w1a; wb1_data = tbl[i].w1d;
            iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; iss_rd_we = tbl[i].iwe;
            iss_src_used = tbl[i].su;
            rd(tbl[i].a0, tbl[i].a1);
            run(50 + i, tbl[i].e0, tbl[i].e1, tbl[i].eb, tbl[i].er);
        end

        idle(); iss_valid = 1; iss_rd = 9; iss_rd_we = 1;
        run(100, 0, 0, 0, 1);
        idle(); wb0_valid = 1; wb0_addr = 9; wb0_data = 64'h9;
        iss_valid = 1; iss_rd = 9; iss_rd_we = 1; rd(1, 0);
        run(101, 64'h11, 0, 32'h200, 1);
        idle(); rd(9, 0);
        run(102, 64'h9, 0, 32'h200, 1);
        idle(); wb1_valid = 1; wb1_addr = 9; wb1_data = 64'h19; rd(1, 0);
        run(103, 64'h11, 0, 32'h200, 1);
        idle(); rd(9, 0);
        run(104, 64'h19, 0, 0, 1);

        idle(); iss_valid = 1; iss_rd = 7; iss_rd_we = 1;
        run(200, 0, 0, 0, 1);
        idle(); iss_valid = 1; iss_src_used = 2'b01; rd(7, 0);
        run(201, 64'h77, 0, 32'h80, 0);
        wb0_valid = 1; wb0_addr = 7; wb0_data = 64'h1234;
`ifdef REGFILE_SB_BYPASS_EN
        run(202, 64'h1234, 0, 32'h80, 1);
`else
        run(202, 64'h77, 0, 32'h80, 0);
`endif
        wb0_valid = 0;
        run(203, 64'h1234, 0, 0, 1);

`ifdef REGFILE_SB_BYPASS_EN
        idle(); wb0_valid = 1; wb0_addr = 4; wb0_data = 64'hA;
        wb1_valid = 1; wb1_addr = 4; wb1_data = 64'hB; rd(4, 0);
        run(400, 64'hB, 0, 0, 1);
`endif

        idle(); iss_valid = 1; iss_rd = 3; iss_rd_we = 1; rd(3, 0);
        run(300, 0, 0, 0, 1);
        idle(); wb0_valid = 1; wb0_addr = 3; wb0_data = 64'hDEAD;
        iss_valid = 1; iss_rd = 6; iss_rd_we = 1; rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        idle(); rd(3, 5);
        run(301, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
